apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
Round-robin arbiter and APB master sequencer that shares one APB bus between NREQ local requesters.
- Each requester posts a single read or write command.
- The block grants one requester at a time and runs the APB SETUP/ACCESS phases for it.
- It returns an ack, read data and error to the granted requester.
- It sits between the requesting agents and the APB slave fabric, in the PCLK domain.

Parameters:
NREQ, 2, number of requesters
ADDR_W, 5, APB address width
DATA_W, 32, APB data width
TIMEOUT, 16, max ACCESS cycles waiting for PREADY before forced error termination

Ports:
PCLK  in  1  clock, rising edge
PRESETn  in  1  reset, synchronous, active-low
req_valid  in  NREQ  per-requester command pending; held until ack
req_write  in  NREQ  1=write, 0=read
req_addr  in  NREQ*ADDR_W  packed addresses, index i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NREQ*DATA_W  packed write data, index i at [i*DATA_W +: DATA_W]
req_ack  out  NREQ  one-cycle completion pulse to the owner
req_rdata  out  DATA_W  read data for the completed read
req_err  out  1  error flag, valid with req_ack
grant  out  NREQ  one-hot current owner, 0 when idle
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PREADY  in  1  slave ready
PRDATA  in  DATA_W  slave read data
PSLVERR  in  1  slave error

Behaviour:
- Reset, PRESETn low at a rising edge: state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ack, req_rdata, req_err and grant all 0.
  - Round-robin pointer is set so index 0 has highest priority.
  - Reset applies from any state, including mid-ACCESS. The aborted transfer gets no ack.
- All outputs are registered.
- FSM IDLE, SETUP, ACCESS.
- IDLE:
  - Eligible = req_valid & ~req_ack. This masks the requester being acked this cycle, so its command is not reissued.
  - If any requester is eligible, pick the first one searching upward (with wrap) from (last granted + 1) mod NREQ.
  - Latch its write, addr and wdata; set grant one-hot; update the pointer; go to SETUP.
  - On entering SETUP: PSEL=1, PENABLE=0, PWRITE=latched write, PADDR=latched addr, PWDATA=latched wdata for writes and 0 for reads.
- SETUP: unconditional transition to ACCESS; PENABLE=1, all other bus signals unchanged.
- ACCESS:
  - Wait counter starts at 0 and increments each ACCESS cycle with PREADY=0.
  - PREADY=1 sampled:
    - req_ack[owner]=1 for one cycle.
    - req_err=PSLVERR.
    - req_rdata=PRDATA for reads; unchanged for writes.
    - PSEL, PENABLE and grant go to 0; state goes to IDLE.
  - Counter reaches TIMEOUT with PREADY still 0:
    - Same completion, but req_err=1 and req_rdata=0 for reads.
    - Bus released.
- Latency with zero wait states:
  - req_valid sampled at edge 1.
  - PSEL visible after edge 1.
  - PENABLE visible after edge 2.
  - req_ack visible after edge 3.
  - Each PREADY wait cycle adds one cycle.
- At least one IDLE cycle (PSEL=0) between consecutive transfers.
- req_valid deasserting mid-transfer has no effect, because fields are latched. Requester field changes after grant are ignored.
- Simultaneous requests are served strictly round-robin. With all NREQ continuously requesting, each is granted once per NREQ transfers, with no starvation.
- req_err and req_rdata hold their values until the next completion.

Test Plan:
- Write, zero wait: req0 write addr 0x12 data 0xDEADBEEF, PREADY=1 → PSEL after edge 1; PENABLE, PWRITE=1, PADDR=0x12, PWDATA=0xDEADBEEF after edge 2; req_ack=2'b01 after edge 3 for one cycle; req_err=0.
- Read with wait states: req1 read addr 0x15, PRDATA=0xDABBCAFE, PREADY low for 2 ACCESS cycles → req_ack=2'b10 after edge 5; req_rdata=0xDABBCAFE; PWDATA=0 throughout.
- Contention: req0 and req1 held high continuously from reset → grant sequence 01,10,01,10; each ack followed by one PSEL=0 cycle; no duplicate issue for the just-acked requester.
- Timeout: PREADY stuck 0 on a req0 read → ack after 16 ACCESS cycles with req_err=1, req_rdata=0; PSEL=0 on the next cycle.
- Slave error: PSLVERR=1 with PREADY=1 on a write → req_err=1 with the ack; the following clean transfer reports req_err=0.
- Reset mid-op: PRESETn=0 during ACCESS → after the next edge all outputs are 0 and no ack is issued; after release, a pending req0 completes normally.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB bus between NREQ requesters
// and sequences the SETUP/ACCESS phases for the granted owner.
module apb_master_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ack,
  output logic [DATA_W-1:0]        req_rdata,
  output logic                     req_err,
  output logic [NREQ-1:0]          grant,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [ADDR_W-1:0]        PADDR,
  output logic [DATA_W-1:0]        PWDATA,
  input  logic                     PREADY,
  input  logic [DATA_W-1:0]        PRDATA,
  input  logic                     PSLVERR
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CW-1:0]       wcnt_q, wcnt_d;

  logic [NREQ-1:0]     elig;
  logic                found;
  logic [PW-1:0]       pick;
  logic [PW-1:0]       cand;
  int                  idx;

  // Search upward from the slot after the last owner; the requester
  // being acked this cycle is masked so it is not reissued.
  always_comb begin
    elig  = req_valid & ~ack_q;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx  = (int'(ptr_q) + 1 + i) % NREQ;
      cand = PW'(idx);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    ack_d     = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    wcnt_d    = wcnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = SETUP;
          ptr_d     = pick;
          grant_d   = NREQ'(1) << pick;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = req_write[pick];
          paddr_d   = req_addr[pick*ADDR_W +: ADDR_W];
          pwdata_d  = req_write[pick]
                    ? req_wdata[pick*DATA_W +: DATA_W]
                    : '0;
          wcnt_d    = '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY || wcnt_q == CW'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          ack_d     = grant_q;
          grant_d   = '0;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (PREADY) begin
            err_d = PSLVERR;
            if (!pwrite_q) rdata_d = PRDATA;
          end else begin
            // Slave never answered: force an error completion.
            err_d = 1'b1;
            if (!pwrite_q) rdata_d = '0;
          end
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_RST;
      grant_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      wcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      wcnt_q    <= wcnt_d;
    end
  end

  assign req_ack   = ack_q;
  assign req_rdata = rdata_q;
  assign req_err   = err_q;
  assign grant     = grant_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: slave model plus completion scoreboard.
module tb_apb_master_arbiter;

  logic        PCLK;
  logic        PRESETn;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [9:0]  req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ack;
  logic [31:0] req_rdata;
  logic        req_err;
  logic [1:0]  grant;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int   errors = 0;
  int   checks = 0;
  int   wait_n = 0;
  int   acc_cnt = 0;
  logic stuck = 1'b0;

  typedef struct packed {
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] m_rdata = '0;

  apb_master_arbiter #(
    .NREQ(2), .ADDR_W(5), .DATA_W(32), .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_rdata(req_rdata),
    .req_err(req_err), .grant(grant),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  assign PREADY = PSEL && PENABLE && !stuck && (acc_cnt >= wait_n);

  always @(posedge PCLK)
    acc_cnt <= (PSEL && PENABLE) ? acc_cnt + 1 : 0;

  always @(negedge PCLK) begin
    if (req_ack !== 2'b00) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_ack got=%b want=none", req_ack);
      end else begin
        e = sb.pop_front();
        if (req_ack !== e.ack || req_err !== e.err ||
            req_rdata !== e.rdata) begin
          errors++;
          $display("FAIL sb_completion got ack=%b err=%b rd=%h want ack=%b err=%b rd=%h",
                   req_ack, req_err, req_rdata, e.ack, e.err, e.rdata);
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] own, input logic wr,
                          input logic er, input logic [31:0] rd);
    if (!wr) m_rdata = rd;
    sb.push_back('{ack: own, err: er, rdata: m_rdata});
  endtask

  task automatic wait_ack(input int max, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < max) begin
      @(negedge PCLK);
      n++;
      if (req_ack !== 2'b00) ok = 1'b1;
    end
  endtask

  task automatic set_req(input int i, input logic wr,
                         input logic [4:0] a, input logic [31:0] d);
    req_write[i]          = wr;
    req_addr[i*5 +: 5]    = a;
    req_wdata[i*32 +: 32] = d;
    req_valid[i]          = 1'b1;
  endtask

  task automatic test_reset;
    PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
      errors++;
      $display("FAIL reset_bus got=%b%b%b %h %h want=0",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    checks++;
    if ({req_ack, req_rdata, req_err, grant} !== '0) begin
      errors++;
      $display("FAIL reset_req got ack=%b rd=%h err=%b gnt=%b want=0",
               req_ack, req_rdata, req_err, grant);
    end
    PRESETn = 1'b1;
    m_rdata = '0;
    @(negedge PCLK);
  endtask

  task automatic test_write;
    wait_n = 0;
    set_req(0, 1'b1, 5'h12, 32'hDEADBEEF);
    push_exp(2'b01, 1'b1, 1'b0, '0);
    @(negedge PCLK);
    checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b0 || grant !== 2'b01) begin
      errors++;
      $display("FAIL wr_setup got psel=%b pen=%b gnt=%b want 1 0 01",
               PSEL, PENABLE, grant);
    end
    @(negedge PCLK);
    checks++;
    if (PENABLE !== 1'b1 || PWRITE !== 1'b1 || PADDR !== 5'h12 ||
        PWDATA !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_access got pen=%b pw=%b pa=%h pd=%h want 1 1 12 deadbeef",
               PENABLE, PWRITE, PADDR, PWDATA);
    end
    @(negedge PCLK);
    checks++;
    if (req_ack !== 2'b01 || req_err !== 1'b0 || PSEL !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack got ack=%b err=%b psel=%b want 01 0 0",
               req_ack, req_err, PSEL);
    end
    req_valid[0] = 1'b0;
    @(negedge PCLK);
    checks++;
    if (req_ack !== 2'b00 || PSEL !== 1'b0) begin
      errors++;
      $display("FAIL wr_pulse got ack=%b psel=%b want 00 0", req_ack, PSEL);
    end
  endtask

  task automatic test_read_wait;
    bit pw_bad;
    pw_bad = 1'b0;
    wait_n = 2;
    PRDATA = 32'hDABBCAFE;
    set_req(1, 1'b0, 5'h15, 32'h11111111);
    push_exp(2'b10, 1'b0, 1'b0, 32'hDABBCAFE);
    for (int k = 1; k <= 5; k++) begin
      @(negedge PCLK);
      if (PSEL && PWDATA !== 32'h0) pw_bad = 1'b1;
      if (k < 5) begin
        checks++;
        if (req_ack !== 2'b00) begin
          errors++;
          $display("FAIL rd_early_ack edge=%0d got=%b want=00", k, req_ack);
        end
      end
    end
    checks++;
    if (req_ack !== 2'b10 || req_rdata !== 32'hDABBCAFE) begin
      errors++;
      $display("FAIL rd_ack got ack=%b rd=%h want 10 dabbcafe",
               req_ack, req_rdata);
    end
    checks++;
    if (pw_bad) begin
      errors++;
      $display("FAIL rd_pwdata got=nonzero want=0");
    end
    req_valid[1] = 1'b0;
    wait_n = 0;
    @(negedge PCLK);
  endtask

  task automatic test_contention;
    bit          ok;
    int          n;
    logic [1:0]  want;
    set_req(0, 1'b1, 5'h03, 32'hA0A0A0A0);
    set_req(1, 1'b1, 5'h1C, 32'hB1B1B1B1);
    for (int k = 0; k < 4; k++) push_exp((k % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      while (PSEL !== 1'b1 && n < 20) begin
        @(negedge PCLK);
        n++;
      end
      checks++;
      if (grant !== want) begin
        errors++;
        $display("FAIL cont_grant idx=%0d got=%b want=%b", k, grant, want);
      end
      wait_ack(20, ok);
      checks++;
      if (!ok || PSEL !== 1'b0) begin
        errors++;
        $display("FAIL cont_ack idx=%0d got ok=%0d psel=%b want 1 0",
                 k, ok, PSEL);
      end
      if (k == 3) req_valid = 2'b00;
      @(negedge PCLK);
      checks++;
      if (PSEL !== ((k < 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL cont_gap idx=%0d got psel=%b", k, PSEL);
      end
    end
  endtask

  task automatic test_timeout;
    bit early;
    early = 1'b0;
    stuck = 1'b1;
    set_req(0, 1'b0, 5'h07, '0);
    push_exp(2'b01, 1'b0, 1'b1, 32'h0);
    for (int k = 1; k <= 18; k++) begin
      @(negedge PCLK);
      if (k < 18 && req_ack !== 2'b00) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL to_early got=ack before 16 waits want=none");
    end
    checks++;
    if (req_ack !== 2'b01 || req_err !== 1'b1 || req_rdata !== 32'h0) begin
      errors++;
      $display("FAIL to_ack got ack=%b err=%b rd=%h want 01 1 0",
               req_ack, req_err, req_rdata);
    end
    req_valid[0] = 1'b0;
    stuck = 1'b0;
    @(negedge PCLK);
    checks++;
    if (PSEL !== 1'b0) begin
      errors++;
      $display("FAIL to_release got psel=%b want=0", PSEL);
    end
  endtask

  task automatic test_slverr;
    bit ok;
    PSLVERR = 1'b1;
    set_req(1, 1'b1, 5'h0A, 32'h5A5A5A5A);
    push_exp(2'b10, 1'b1, 1'b1, '0);
    wait_ack(10, ok);
    checks++;
    if (!ok || req_err !== 1'b1) begin
      errors++;
      $display("FAIL se_err got ok=%0d err=%b want 1 1", ok, req_err);
    end
    req_valid[1] = 1'b0;
    PSLVERR = 1'b0;
    PRDATA = 32'h12345678;
    set_req(0, 1'b0, 5'h01, '0);
    push_exp(2'b01, 1'b0, 1'b0, 32'h12345678);
    wait_ack(10, ok);
    checks++;
    if (!ok || req_err !== 1'b0 || req_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL se_clean got ok=%0d err=%b rd=%h want 1 0 12345678",
               ok, req_err, req_rdata);
    end
    req_valid[0] = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic test_reset_midop;
    bit ok;
    stuck = 1'b1;
    set_req(0, 1'b1, 5'h1F, 32'hCAFEF00D);
    repeat (3) @(negedge PCLK);
    checks++;
    if (PENABLE !== 1'b1) begin
      errors++;
      $display("FAIL rm_pre got pen=%b want=1", PENABLE);
    end
    PRESETn = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ack,
         req_rdata, req_err, grant} !== '0) begin
      errors++;
      $display("FAIL rm_zero got psel=%b pen=%b pa=%h pd=%h ack=%b gnt=%b want=0",
               PSEL, PENABLE, PADDR, PWDATA, req_ack, grant);
    end
    m_rdata = '0;
    stuck = 1'b0;
    PRESETn = 1'b1;
    push_exp(2'b01, 1'b1, 1'b0, '0);
    wait_ack(10, ok);
    checks++;
    if (!ok || req_ack !== 2'b01) begin
      errors++;
      $display("FAIL rm_after got ok=%0d ack=%b want 1 01", ok, req_ack);
    end
    req_valid[0] = 1'b0;
    repeat (2) @(negedge PCLK);
  endtask

  initial begin
    PRESETn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    PRDATA    = '0;
    PSLVERR   = 1'b0;
    @(negedge PCLK);
    test_reset();
    test_write();
    test_read_wait();
    test_contention();
    test_timeout();
    test_slverr();
    test_reset_midop();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
